// File: rtl/pong_court.sv
// Parametrised pong / squash court: ball on an N_LEDS light bar,
// BCD scores on a scanned 8-digit seven-segment display.
module pong_court #(
    parameter int N_LEDS    = 16,
    parameter int TICK_DIV  = 25000000,
    parameter int HIT_WIN   = 2,
    parameter int WIN_SCORE = 5,
    parameter int SCAN_DIV  = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rightplayer,
    input  logic              leftplayer,
    input  logic              squash,
    output logic [N_LEDS-1:0] light,
    output logic [7:0]        AN_Out,
    output logic [6:0]        C_Out,
    output logic              game_over
);

    localparam int PW = $clog2(N_LEDS);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] P_MAX  = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] P_BNC  = PW'(N_LEDS - 2);
    localparam logic [PW-1:0] P_LWIN = PW'(N_LEDS - HIT_WIN);
    localparam logic [PW-1:0] P_RWIN = PW'(HIT_WIN - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [7:0] WIN_BCD =
        {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    typedef enum logic [2:0] {
        SERVE_R, SERVE_L, MOVE_L, MOVE_R, OVER
    } state_t;

    state_t        state, st_n;
    logic [PW-1:0] pos, pos_n;
    logic [7:0]    r_score, rs_n;
    logic [7:0]    l_score, ls_n;
    logic          sq_mode, sq_n;
    logic          r_point, l_point;

    logic [2:0]    r_sync, l_sync;
    logic          r_ev, l_ev;
    logic [TW-1:0] tcnt;
    logic          tick;

    logic [SW-1:0] scnt;
    logic [1:0]    slot, slot_n;
    logic [3:0]    digit;
    logic [7:0]    an_n;
    logic [6:0]    seg_n;

    // Two flops of synchroniser, third flop remembers the previous level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            l_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], rightplayer};
            l_sync <= {l_sync[1:0], leftplayer};
        end
    end

    assign r_ev = r_sync[1] & ~r_sync[2];
    assign l_ev = l_sync[1] & ~l_sync[2];
    assign tick = (tcnt == T_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) tcnt <= '0;
        else       tcnt <= tick ? '0 : tcnt + 1'b1;
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)       return v;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        st_n    = state;
        pos_n   = pos;
        rs_n    = r_score;
        ls_n    = l_score;
        sq_n    = sq_mode;
        r_point = 1'b0;
        l_point = 1'b0;
        unique case (state)
            SERVE_R: begin
                sq_n  = squash;
                pos_n = '0;
                if (r_ev) st_n = MOVE_L;
            end
            SERVE_L: begin
                sq_n  = squash;
                pos_n = P_MAX;
                if (squash) begin
                    st_n  = SERVE_R;
                    pos_n = '0;
                end else if (l_ev) begin
                    st_n = MOVE_R;
                end
            end
            MOVE_L: begin
                if (l_ev && !sq_mode) begin
                    if (pos >= P_LWIN) st_n = MOVE_R;
                    else               r_point = 1'b1;
                end else if (tick) begin
                    if (pos != P_MAX) begin
                        pos_n = pos + 1'b1;
                    end else if (sq_mode) begin
                        st_n  = MOVE_R;
                        pos_n = P_BNC;
                    end else begin
                        r_point = 1'b1;
                    end
                end
            end
            MOVE_R: begin
                if (r_ev) begin
                    if (pos <= P_RWIN) begin
                        st_n = MOVE_L;
                        if (sq_mode) rs_n = bcd_inc(r_score);
                    end else begin
                        l_point = 1'b1;
                    end
                end else if (tick) begin
                    if (pos != '0) pos_n = pos - 1'b1;
                    else           l_point = 1'b1;
                end
            end
            default: ;
        endcase
        if (l_point) begin
            ls_n = bcd_inc(l_score);
            if (ls_n == WIN_BCD) begin
                st_n = OVER;
            end else if (sq_mode) begin
                st_n  = SERVE_R;
                pos_n = '0;
            end else begin
                st_n  = SERVE_L;
                pos_n = P_MAX;
            end
        end
        if (r_point) begin
            rs_n = bcd_inc(r_score);
            if (rs_n == WIN_BCD) begin
                st_n = OVER;
            end else begin
                st_n  = SERVE_R;
                pos_n = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= SERVE_R;
            pos       <= '0;
            r_score   <= '0;
            l_score   <= '0;
            sq_mode   <= 1'b0;
            light     <= N_LEDS'(1);
            game_over <= 1'b0;
        end else begin
            state     <= st_n;
            pos       <= pos_n;
            r_score   <= rs_n;
            l_score   <= ls_n;
            sq_mode   <= sq_n;
            light     <= (st_n == OVER) ? '1 : (N_LEDS'(1) << pos_n);
            game_over <= (st_n == OVER);
        end
    end

    assign slot_n = (scnt == S_MAX) ? slot + 2'd1 : slot;

    always_comb begin
        unique case (slot_n)
            2'd0: begin digit = r_score[3:0]; an_n = 8'hFE; end
            2'd1: begin digit = r_score[7:4]; an_n = 8'hFD; end
            2'd2: begin digit = l_score[3:0]; an_n = 8'hBF; end
            default: begin digit = l_score[7:4]; an_n = 8'h7F; end
        endcase
    end

    always_comb begin
        unique case (digit)
            4'd0: seg_n = 7'h40;
            4'd1: seg_n = 7'h79;
            4'd2: seg_n = 7'h24;
            4'd3: seg_n = 7'h30;
            4'd4: seg_n = 7'h19;
            4'd5: seg_n = 7'h12;
            4'd6: seg_n = 7'h02;
            4'd7: seg_n = 7'h78;
            4'd8: seg_n = 7'h00;
            4'd9: seg_n = 7'h10;
            default: seg_n = 7'h7F;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scnt   <= '0;
            slot   <= '0;
            AN_Out <= 8'hFE;
            C_Out  <= 7'h40;
        end else begin
            scnt   <= (scnt == S_MAX) ? '0 : scnt + 1'b1;
            slot   <= slot_n;
            AN_Out <= an_n;
            C_Out  <= seg_n;
        end
    end

endmodule

// File: tb/tb_pong_court.sv
// Scenario bench for pong_court: tennis rallies, squash, game over
// and display scan; a second court with a higher win score shows R=12 L=07.
module tb_pong_court;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rp = '0;
    logic [1:0] lp = '0;
    logic [1:0] sq = '0;
    logic [7:0] lt0, lt1, an0, an1;
    logic [6:0] c0, c1;
    logic       go0, go1;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_q[$];
    logic [14:0] disp_q[$];

    pong_court #(.N_LEDS(8), .TICK_DIV(4), .HIT_WIN(2),
                 .WIN_SCORE(3), .SCAN_DIV(2)) u_dut (
        .clock(clock), .reset(reset),
        .rightplayer(rp[0]), .leftplayer(lp[0]), .squash(sq[0]),
        .light(lt0), .AN_Out(an0), .C_Out(c0), .game_over(go0)
    );

    pong_court #(.N_LEDS(8), .TICK_DIV(4), .HIT_WIN(2),
                 .WIN_SCORE(20), .SCAN_DIV(2)) u_disp (
        .clock(clock), .reset(reset),
        .rightplayer(rp[1]), .leftplayer(lp[1]), .squash(sq[1]),
        .light(lt1), .AN_Out(an1), .C_Out(c1), .game_over(go1)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lt(input int s);
        return (s != 0) ? lt1 : lt0;
    endfunction

    function automatic logic [7:0] an_of(input int s);
        return (s != 0) ? an1 : an0;
    endfunction

    function automatic logic [6:0] c_of(input int s);
        return (s != 0) ? c1 : c0;
    endfunction

    task automatic press(input int s, input bit right);
        if (right) rp[s] = 1'b1;
        else       lp[s] = 1'b1;
        repeat (3) @(negedge clock);
        rp[s] = 1'b0;
        lp[s] = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_light(input int s, input logic [7:0] v,
                              input string nm);
        for (int i = 0; i < 300; i++) begin
            if (lt(s) == v) return;
            @(negedge clock);
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, light=%h required %h", nm, lt(s), v);
    endtask

    task automatic next_light(input int s, input logic [7:0] prev,
                              output logic [7:0] v, output int cyc);
        cyc = 0;
        while (lt(s) == prev && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        v = lt(s);
    endtask

    // Waits for a fresh entry into slot a so C_Out reflects current scores.
    task automatic wait_an(input int s, input logic [7:0] a,
                           input string nm);
        int i = 0;
        while (an_of(s) == a && i < 20) begin
            @(negedge clock);
            i++;
        end
        while (an_of(s) != a && i < 20) begin
            @(negedge clock);
            i++;
        end
        if (an_of(s) != a) begin
            checks++;
            errors++;
            $display("FAIL %s: anode %h never seen, AN=%h", nm, a, an_of(s));
        end
    endtask

    task automatic run_queue(input int s, input logic [7:0] start,
                             input bit first_free, input string nm);
        logic [7:0] prev, got, e;
        int cyc;
        bit first;
        prev  = start;
        first = first_free;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_light(s, prev, got, cyc);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: light=%h required %h", nm, got, e);
            end
            if (!first) begin
                checks++;
                if (cyc != 4) begin
                    errors++;
                    $display("FAIL %s step: %0d clocks required 4", nm, cyc);
                end
            end
            first = 1'b0;
            prev  = got;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks += 4;
        if (lt0 !== 8'h01) begin
            errors++;
            $display("FAIL reset light: %h required 01", lt0);
        end
        if (an0 !== 8'hFE) begin
            errors++;
            $display("FAIL reset AN: %h required FE", an0);
        end
        if (c0 !== 7'h40) begin
            errors++;
            $display("FAIL reset C: %h required 40", c0);
        end
        if (go0 !== 1'b0) begin
            errors++;
            $display("FAIL reset game_over: %b required 0", go0);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_serve;
        press(0, 1'b1);
        for (int i = 1; i < 8; i++) exp_q.push_back(8'(1 << i));
        exp_q.push_back(8'h01);
        run_queue(0, 8'h01, 1'b1, "serve");
        wait_an(0, 8'hFE, "serve AN0");
        checks++;
        if (c0 !== 7'h79) begin
            errors++;
            $display("FAIL serve right score: C=%h required 79", c0);
        end
        wait_an(0, 8'hBF, "serve AN6");
        checks++;
        if (c0 !== 7'h40) begin
            errors++;
            $display("FAIL serve left score: C=%h required 40", c0);
        end
    endtask

    task automatic test_return;
        press(0, 1'b1);
        wait_light(0, 8'h40, "return wait 40");
        press(0, 1'b0);
        exp_q = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
        run_queue(0, 8'h40, 1'b1, "left return");
        press(0, 1'b1);
        exp_q = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        run_queue(0, 8'h02, 1'b1, "right return");
        wait_an(0, 8'hFE, "return AN0");
        checks++;
        if (c0 !== 7'h24) begin
            errors++;
            $display("FAIL return right score: C=%h required 24", c0);
        end
        wait_an(0, 8'hBF, "return AN6");
        checks++;
        if (c0 !== 7'h40) begin
            errors++;
            $display("FAIL return left score: C=%h required 40", c0);
        end
    endtask

    task automatic test_early_swing;
        press(0, 1'b1);
        wait_light(0, 8'h40, "early wait 40");
        press(0, 1'b0);
        wait_light(0, 8'h20, "early wait 20");
        press(0, 1'b0);
        wait_light(0, 8'h08, "early wait 08");
        press(0, 1'b1);
        checks++;
        if (lt0 !== 8'h80) begin
            errors++;
            $display("FAIL early light: %h required 80", lt0);
        end
        repeat (8) @(negedge clock);
        checks++;
        if (lt0 !== 8'h80) begin
            errors++;
            $display("FAIL early serve_l hold: %h required 80", lt0);
        end
        wait_an(0, 8'hBF, "early AN6");
        checks++;
        if (c0 !== 7'h79) begin
            errors++;
            $display("FAIL early left score: C=%h required 79", c0);
        end
        wait_an(0, 8'hFE, "early AN0");
        checks++;
        if (c0 !== 7'h24) begin
            errors++;
            $display("FAIL early right score: C=%h required 24", c0);
        end
    endtask

    task automatic test_game_over;
        press(0, 1'b0);
        wait_light(0, 8'h01, "over wait 01");
        wait_light(0, 8'h80, "over wait 80");
        press(0, 1'b0);
        wait_light(0, 8'h01, "over wait 01b");
        wait_light(0, 8'hFF, "over wait FF");
        checks++;
        if (go0 !== 1'b1) begin
            errors++;
            $display("FAIL over game_over: %b required 1", go0);
        end
        wait_an(0, 8'hBF, "over AN6");
        checks++;
        if (c0 !== 7'h30) begin
            errors++;
            $display("FAIL over left units: C=%h required 30", c0);
        end
        wait_an(0, 8'h7F, "over AN7");
        checks++;
        if (c0 !== 7'h40) begin
            errors++;
            $display("FAIL over left tens: C=%h required 40", c0);
        end
        press(0, 1'b1);
        press(0, 1'b0);
        repeat (10) @(negedge clock);
        checks += 2;
        if (lt0 !== 8'hFF || go0 !== 1'b1) begin
            errors++;
            $display("FAIL over hold: light=%h go=%b required FF 1", lt0, go0);
        end
        wait_an(0, 8'hBF, "over AN6 hold");
        if (c0 !== 7'h30) begin
            errors++;
            $display("FAIL over score hold: C=%h required 30", c0);
        end
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (lt0 !== 8'h01) begin
            errors++;
            $display("FAIL async reset light: %h required 01", lt0);
        end
        if (go0 !== 1'b0) begin
            errors++;
            $display("FAIL async reset game_over: %b required 0", go0);
        end
        if (an0 !== 8'hFE) begin
            errors++;
            $display("FAIL async reset AN: %h required FE", an0);
        end
        if (c0 !== 7'h40) begin
            errors++;
            $display("FAIL async reset C: %h required 40", c0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_squash;
        sq[0] = 1'b1;
        @(negedge clock);
        press(0, 1'b1);
        for (int i = 1; i < 8; i++) exp_q.push_back(8'(1 << i));
        for (int i = 6; i > 0; i--) exp_q.push_back(8'(1 << i));
        run_queue(0, 8'h01, 1'b1, "squash bounce");
        press(0, 1'b1);
        for (int r = 0; r < 2; r++) begin
            wait_light(0, 8'h80, "squash rally 80");
            wait_light(0, 8'h02, "squash rally 02");
            press(0, 1'b1);
        end
        wait_an(0, 8'hFE, "squash AN0");
        checks++;
        if (c0 !== 7'h30) begin
            errors++;
            $display("FAIL squash rallies: C=%h required 30", c0);
        end
        for (int m = 0; m < 3; m++) begin
            if (m > 0) press(0, 1'b1);
            wait_light(0, 8'h80, "squash miss 80");
            wait_light(0, 8'h01, "squash miss 01");
            if (m < 2) repeat (6) @(negedge clock);
        end
        wait_light(0, 8'hFF, "squash over");
        checks++;
        if (go0 !== 1'b1) begin
            errors++;
            $display("FAIL squash game_over: %b required 1", go0);
        end
        wait_an(0, 8'hBF, "squash AN6");
        checks++;
        if (c0 !== 7'h30) begin
            errors++;
            $display("FAIL squash misses: C=%h required 30", c0);
        end
        wait_an(0, 8'hFE, "squash AN0 end");
        checks++;
        if (c0 !== 7'h30) begin
            errors++;
            $display("FAIL squash rally hold: C=%h required 30", c0);
        end
    endtask

    task automatic test_display_scan;
        logic [14:0] e;
        int cyc;
        sq[1] = 1'b1;
        @(negedge clock);
        press(1, 1'b1);
        for (int r = 0; r < 12; r++) begin
            wait_light(1, 8'h80, "disp rally 80");
            wait_light(1, 8'h02, "disp rally 02");
            press(1, 1'b1);
        end
        for (int m = 0; m < 7; m++) begin
            if (m > 0) press(1, 1'b1);
            wait_light(1, 8'h80, "disp miss 80");
            wait_light(1, 8'h01, "disp miss 01");
            repeat (6) @(negedge clock);
        end
        checks++;
        if (go1 !== 1'b0) begin
            errors++;
            $display("FAIL disp game_over: %b required 0", go1);
        end
        wait_an(1, 8'hFE, "disp start");
        checks++;
        if (c1 !== 7'h24) begin
            errors++;
            $display("FAIL disp AN0 digit: C=%h required 24", c1);
        end
        disp_q = '{{8'hFD, 7'h79}, {8'hBF, 7'h78}, {8'h7F, 7'h40},
                   {8'hFE, 7'h24}, {8'hFD, 7'h79}};
        while (disp_q.size() > 0) begin
            logic [7:0] prev_an;
            e = disp_q.pop_front();
            prev_an = an1;
            cyc = 0;
            while (an1 == prev_an && cyc < 10) begin
                @(negedge clock);
                cyc++;
            end
            checks += 2;
            if ({an1, c1} !== e) begin
                errors++;
                $display("FAIL disp scan: AN=%h C=%h required AN=%h C=%h",
                         an1, c1, e[14:7], e[6:0]);
            end
            if (cyc != 2) begin
                errors++;
                $display("FAIL disp slot time: %0d clocks required 2", cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_return();
        test_early_swing();
        test_game_over();
        test_squash();
        test_display_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
